// File: rtl/jk_sync_counter_if.sv
// Control and observation bundle for jk_sync_counter: count controls and load
// data in; state, complement, terminal count and per-cell J/K excitation out.
interface jk_sync_counter_if #(parameter int N = 4);
  logic         EN;
  logic         UD;
  logic         LD;
  logic [N-1:0] D;
  logic [N-1:0] Q;
  logic [N-1:0] Q_;
  logic         TC;
  logic [N-1:0] Jv;
  logic [N-1:0] Kv;

  modport master (output EN, UD, LD, D, input Q, Q_, TC, Jv, Kv);
  modport slave  (input EN, UD, LD, D, output Q, Q_, TC, Jv, Kv);
endinterface

// File: rtl/jk_sync_counter.sv
// Up/down modulo-MOD counter built from a bank of JK bit cells.
// Define JK_CNT_SATURATE_EN to stop at the bounds instead of wrapping.
module jk_sync_counter #(
  parameter int N   = 4,
  parameter int MOD = 16
) (
  input  logic C,
  input  logic R_,
  jk_sync_counter_if.slave bus
);

  localparam logic [N-1:0] MAX = N'(MOD - 1);

  logic [N-1:0] q_r;
  logic [N-1:0] qn_r;
  logic [N-1:0] dc;
  logic [N-1:0] nxt;
  logic [N-1:0] j;
  logic [N-1:0] k;
  logic [N-1:0] q_jk;
  logic         at_bound;
  logic         tc;

  // Out-of-range load values clamp to the top of the count range.
  assign dc = (32'(bus.D) < 32'(MOD)) ? bus.D : MAX;

  always_comb begin
    at_bound = bus.UD ? (q_r == MAX) : (q_r == '0);
    nxt      = q_r;
    if (bus.UD)
      nxt = (q_r == MAX) ? '0 : q_r + N'(1);
    else
      nxt = (q_r == '0) ? MAX : q_r - N'(1);
`ifdef JK_CNT_SATURATE_EN
    if (at_bound)
      nxt = q_r;
`endif
  end

  always_comb begin
    j  = '0;
    k  = '0;
    tc = 1'b0;
    if (!R_) begin
      k = '1;
    end else if (bus.LD) begin
      j = dc;
      k = ~dc;
    end else if (bus.EN) begin
      // Toggle-only excitation: changing bits get J=K=1, the rest J=K=0.
      j  = q_r ^ nxt;
      k  = q_r ^ nxt;
      tc = at_bound;
    end
  end

  assign q_jk = (j & ~q_r) | (~k & q_r);

  always_ff @(posedge C) begin
    q_r  <= q_jk;
    qn_r <= ~q_jk;
  end

  assign bus.Q  = q_r;
  assign bus.Q_ = qn_r;
  assign bus.TC = tc;
  assign bus.Jv = j;
  assign bus.Kv = k;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed vector bench for jk_sync_counter: a MOD=10 and a MOD=16 instance
// share stimulus; each vector names which instance it checks.
module tb_jk_sync_counter;

  logic C;
  logic R_;
  logic en, ud, ld;
  logic [3:0] d;

  int total = 0;
  int bad   = 0;

  jk_sync_counter_if #(.N(4)) bus_a ();
  jk_sync_counter_if #(.N(4)) bus_b ();

  assign bus_a.EN = en;
  assign bus_a.UD = ud;
  assign bus_a.LD = ld;
  assign bus_a.D  = d;
  assign bus_b.EN = en;
  assign bus_b.UD = ud;
  assign bus_b.LD = ld;
  assign bus_b.D  = d;

  jk_sync_counter #(.N(4), .MOD(10)) dut_a (.C(C), .R_(R_), .bus(bus_a));
  jk_sync_counter #(.N(4), .MOD(16)) dut_b (.C(C), .R_(R_), .bus(bus_b));

  initial C = 1'b0;
  always #5 C = ~C;

  typedef struct {
    logic       r_n;
    logic       ld;
    logic       en;
    logic       ud;
    logic [3:0] d;
    logic [3:0] jv;
    logic [3:0] kv;
    logic       tc;
    logic [3:0] q;
    bit         b;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r_n, input logic l, input logic e, input logic u,
                     input logic [3:0] dv, input logic [3:0] jv, input logic [3:0] kv,
                     input logic t, input logic [3:0] q, input bit b);
    vec_t v;
    v.r_n = r_n; v.ld = l; v.en = e; v.ud = u; v.d = dv;
    v.jv = jv; v.kv = kv; v.tc = t; v.q = q; v.b = b;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    R_ = 1'b0; en = 1'b1; ud = 1'b1; ld = 1'b1; d = 4'hA;

    // modulo-10 instance: reset with LD/EN high
    add(0,1,1,1,4'hA, 4'h0,4'hF,0,4'h0, 0);
    add(0,1,1,1,4'hA, 4'h0,4'hF,0,4'h0, 0);
    // count up 0..9 and across the wrap
    add(1,0,1,1,4'h0, 4'h1,4'h1,0,4'h1, 0);
    add(1,0,1,1,4'h0, 4'h3,4'h3,0,4'h2, 0);
    add(1,0,1,1,4'h0, 4'h1,4'h1,0,4'h3, 0);
    add(1,0,1,1,4'h0, 4'h7,4'h7,0,4'h4, 0);
    add(1,0,1,1,4'h0, 4'h1,4'h1,0,4'h5, 0);
    add(1,0,1,1,4'h0, 4'h3,4'h3,0,4'h6, 0);
    add(1,0,1,1,4'h0, 4'h1,4'h1,0,4'h7, 0);
    add(1,0,1,1,4'h0, 4'hF,4'hF,0,4'h8, 0);
    add(1,0,1,1,4'h0, 4'h1,4'h1,0,4'h9, 0);
`ifdef JK_CNT_SATURATE_EN
    add(1,0,1,1,4'h0, 4'h0,4'h0,1,4'h9, 0);
    add(1,0,1,1,4'h0, 4'h0,4'h0,1,4'h9, 0);
    add(1,0,1,1,4'h0, 4'h0,4'h0,1,4'h9, 0);
`else
    add(1,0,1,1,4'h0, 4'h9,4'h9,1,4'h0, 0);
    add(1,0,1,1,4'h0, 4'h1,4'h1,0,4'h1, 0);
    add(1,0,1,1,4'h0, 4'h3,4'h3,0,4'h2, 0);
`endif
    // load 2, count down across the wrap
    add(1,1,0,0,4'h2, 4'h2,4'hD,0,4'h2, 0);
    add(1,0,1,0,4'h0, 4'h3,4'h3,0,4'h1, 0);
    add(1,0,1,0,4'h0, 4'h1,4'h1,0,4'h0, 0);
`ifdef JK_CNT_SATURATE_EN
    add(1,0,1,0,4'h0, 4'h0,4'h0,1,4'h0, 0);
    add(1,0,1,0,4'h0, 4'h0,4'h0,1,4'h0, 0);
`else
    add(1,0,1,0,4'h0, 4'h9,4'h9,1,4'h9, 0);
    add(1,0,1,0,4'h0, 4'h1,4'h1,0,4'h8, 0);
`endif
    // load exactly MOD-1, then LD+EN at the up bound with an over-range D
    add(1,1,0,1,4'h9, 4'h9,4'h6,0,4'h9, 0);
    add(1,1,1,1,4'hC, 4'h9,4'h6,0,4'h9, 0);
    add(1,1,1,1,4'hA, 4'h9,4'h6,0,4'h9, 0);
    // direction flips with no gap
    add(1,0,1,0,4'h0, 4'h1,4'h1,0,4'h8, 0);
    // load 5, hold three edges, then reset mid-count
    add(1,1,0,1,4'h5, 4'h5,4'hA,0,4'h5, 0);
    add(1,0,0,1,4'h0, 4'h0,4'h0,0,4'h5, 0);
    add(1,0,0,0,4'h0, 4'h0,4'h0,0,4'h5, 0);
    add(1,0,0,1,4'h0, 4'h0,4'h0,0,4'h5, 0);
    add(0,0,1,1,4'h0, 4'h0,4'hF,0,4'h0, 0);
    add(1,0,1,1,4'h0, 4'h1,4'h1,0,4'h1, 0);

    // modulo-16 instance: natural wrap (or saturation) at the power-of-two bound
    add(1,1,0,1,4'hE, 4'hE,4'h1,0,4'hE, 1);
    add(1,0,1,1,4'h0, 4'h1,4'h1,0,4'hF, 1);
`ifdef JK_CNT_SATURATE_EN
    add(1,0,1,1,4'h0, 4'h0,4'h0,1,4'hF, 1);
    add(1,0,1,1,4'h0, 4'h0,4'h0,1,4'hF, 1);
    add(1,0,1,1,4'h0, 4'h0,4'h0,1,4'hF, 1);
`else
    add(1,0,1,1,4'h0, 4'hF,4'hF,1,4'h0, 1);
    add(1,0,1,1,4'h0, 4'h1,4'h1,0,4'h1, 1);
    add(1,0,1,1,4'h0, 4'h3,4'h3,0,4'h2, 1);
`endif
    add(1,1,0,0,4'h1, 4'h1,4'hE,0,4'h1, 1);
    add(1,0,1,0,4'h0, 4'h1,4'h1,0,4'h0, 1);
`ifdef JK_CNT_SATURATE_EN
    add(1,0,1,0,4'h0, 4'h0,4'h0,1,4'h0, 1);
    add(1,0,1,0,4'h0, 4'h0,4'h0,1,4'h0, 1);
`else
    add(1,0,1,0,4'h0, 4'hF,4'hF,1,4'hF, 1);
    add(1,0,1,0,4'h0, 4'h1,4'h1,0,4'hE, 1);
`endif

    @(posedge C);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      R_ = vecs[i].r_n; ld = vecs[i].ld; en = vecs[i].en;
      ud = vecs[i].ud;  d  = vecs[i].d;
      @(negedge C);
      if (vecs[i].b) begin
        check("jv", i, bus_b.Jv, vecs[i].jv);
        check("kv", i, bus_b.Kv, vecs[i].kv);
        check("tc", i, {3'b000, bus_b.TC}, {3'b000, vecs[i].tc});
      end else begin
        check("jv", i, bus_a.Jv, vecs[i].jv);
        check("kv", i, bus_a.Kv, vecs[i].kv);
        check("tc", i, {3'b000, bus_a.TC}, {3'b000, vecs[i].tc});
      end
      @(posedge C);
      #1;
      if (vecs[i].b) begin
        check("q",  i, bus_b.Q,  vecs[i].q);
        check("qn", i, bus_b.Q_, ~vecs[i].q);
      end else begin
        check("q",  i, bus_a.Q,  vecs[i].q);
        check("qn", i, bus_a.Q_, ~vecs[i].q);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
